// File: rtl/param_seq_detect_if.sv
// Serial pattern detector bus: bit stream, runtime config and match outputs.
// Ports: master drives stream/config/clear; slave returns seq_seen, match_count, count_sat.
interface param_seq_detect_if #(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               inp_valid;
    logic               inp_bit;
    logic               cfg_load;
    logic [SEQ_LEN-1:0] cfg_pattern;
    logic               cfg_overlap;
    logic               cnt_clear;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    modport master (
        output inp_valid, inp_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clear,
        input  seq_seen, match_count, count_sat
    );

    modport slave (
        input  inp_valid, inp_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clear,
        output seq_seen, match_count, count_sat
    );
endinterface

// File: rtl/param_seq_detect.sv
// Parametrised serial bit-pattern detector with programmable pattern/overlap,
// input-valid qualifier and a saturating match counter.
// Ports: clk, reset (sync, active-high), bus (slave modport of param_seq_detect_if):
//   inp_valid/inp_bit stream in, cfg_load/cfg_pattern/cfg_overlap reprogram,
//   cnt_clear zeroes the counter; seq_seen/match_count/count_sat are registered outputs.
module param_seq_detect #(
    parameter int                 SEQ_LEN         = 4,
    parameter logic [SEQ_LEN-1:0] DEFAULT_PATTERN = SEQ_LEN'(4'b1011),
    parameter logic               DEFAULT_OVERLAP = 1'b1,
    parameter int                 CNT_W           = 8
) (
    input logic              clk,
    input logic              reset,
    param_seq_detect_if.slave bus
);
    localparam int                FW       = $clog2(SEQ_LEN);
    localparam logic [FW-1:0]     FILL_MAX = FW'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [SEQ_LEN-1:0] pattern;
    logic               overlap;
    // The oldest bit is shifted out by the candidate itself, so only
    // SEQ_LEN-1 history bits ever need to be stored.
    logic [SEQ_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [SEQ_LEN-1:0] cand;
    logic               match;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    assign cand  = {hist, bus.inp_bit};
    assign match = bus.inp_valid && !bus.cfg_load
                && (fill == FILL_MAX) && (cand == pattern);

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern     <= DEFAULT_PATTERN;
            overlap     <= DEFAULT_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            seq_seen    <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            seq_seen <= match;

            if (bus.cfg_load) begin
                pattern <= bus.cfg_pattern;
                overlap <= bus.cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (bus.inp_valid) begin
                if (match && !overlap) begin
                    // Non-overlapping: the next match needs a full fresh window.
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= cand[SEQ_LEN-2:0];
                    if (fill != FILL_MAX) begin
                        fill <= fill + FW'(1);
                    end
                end
            end

            // Clear wins over a same-edge match; seq_seen still pulses.
            if (bus.cnt_clear) begin
                match_count <= '0;
                count_sat   <= 1'b0;
            end else if (match && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
                count_sat   <= ((match_count + CNT_W'(1)) == CNT_MAX);
            end
        end
    end

    assign bus.seq_seen    = seq_seen;
    assign bus.match_count = match_count;
    assign bus.count_sat   = count_sat;
endmodule

// File: tb/tb_param_seq_detect.sv
// Scoreboard bench for param_seq_detect: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream; a queue-based reference model predicts each cycle.
module tb_param_seq_detect;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inp_valid = 1'b0;
    logic inp_bit = 1'b0;
    logic cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic cfg_overlap = 1'b0;
    logic cnt_clear = 1'b0;

    always #5 clk = ~clk;

    param_seq_detect_if #(.SEQ_LEN(4), .CNT_W(8)) if0 ();
    param_seq_detect_if #(.SEQ_LEN(4), .CNT_W(2)) if1 ();

    assign if0.inp_valid   = inp_valid;
    assign if0.inp_bit     = inp_bit;
    assign if0.cfg_load    = cfg_load;
    assign if0.cfg_pattern = cfg_pattern;
    assign if0.cfg_overlap = cfg_overlap;
    assign if0.cnt_clear   = cnt_clear;
    assign if1.inp_valid   = inp_valid;
    assign if1.inp_bit     = inp_bit;
    assign if1.cfg_load    = cfg_load;
    assign if1.cfg_pattern = cfg_pattern;
    assign if1.cfg_overlap = cfg_overlap;
    assign if1.cnt_clear   = cnt_clear;

    param_seq_detect #(.CNT_W(8)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    param_seq_detect #(.CNT_W(2)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    typedef struct {
        bit seen;
        int c0;
        int c1;
        bit s0;
        bit s1;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // Reference model: the valid bits received since the last window reset,
    // trimmed to the most recent four; oldest element is the pattern MSB.
    bit hq[$];
    logic [3:0] m_pat = 4'b1011;
    bit m_ovl = 1'b1;
    int m_c0 = 0;
    int m_c1 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit v, input bit b, input bit ld,
                         input logic [3:0] p, input bit o, input bit clr);
        exp_t e;
        bit m;
        @(negedge clk);
        reset = rst;
        inp_valid = v;
        inp_bit = b;
        cfg_load = ld;
        cfg_pattern = p;
        cfg_overlap = o;
        cnt_clear = clr;
        m = 1'b0;
        if (rst) begin
            m_pat = 4'b1011;
            m_ovl = 1'b1;
            hq.delete();
            m_c0 = 0;
            m_c1 = 0;
        end else begin
            if (ld) begin
                m_pat = p;
                m_ovl = o;
                hq.delete();
            end else if (v) begin
                hq.push_back(b);
                if (hq.size() > 4) void'(hq.pop_front());
                if (hq.size() == 4 && {hq[0], hq[1], hq[2], hq[3]} == m_pat) m = 1'b1;
                if (m && !m_ovl) hq.delete();
            end
            if (clr) begin
                m_c0 = 0;
                m_c1 = 0;
            end else if (m) begin
                if (m_c0 < 255) m_c0++;
                if (m_c1 < 3) m_c1++;
            end
        end
        e.seen = m;
        e.c0 = m_c0;
        e.c1 = m_c1;
        e.s0 = (m_c0 == 255);
        e.s1 = (m_c1 == 3);
        exp_q.push_back(e);
    endtask

    task automatic bit_in(input bit b);
        drive(0, 1, b, 0, 4'b0000, 0, 0);
    endtask

    task automatic idle();
        drive(0, 0, 1'($urandom), 0, 4'b0000, 0, 0);
    endtask

    task automatic load(input logic [3:0] p, input bit o, input bit clr);
        drive(0, 1, 1'($urandom), 1, p, o, clr);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seq_seen0", int'(if0.seq_seen), int'(e.seen));
            chk("seq_seen1", int'(if1.seq_seen), int'(e.seen));
            chk("match_count0", int'(if0.match_count), e.c0);
            chk("count_sat0", int'(if0.count_sat), int'(e.s0));
            chk("match_count1", int'(if1.match_count), e.c1);
            chk("count_sat1", int'(if1.count_sat), int'(e.s1));
        end
    end

    bit s1[7] = '{1, 0, 1, 1, 0, 1, 1};

    initial begin
        // Reset state.
        drive(1, 0, 0, 0, 4'b0000, 0, 0);
        drive(1, 0, 0, 0, 4'b0000, 0, 0);
        after_edge();
        chk("reset_count", int'(if0.match_count), 0);
        chk("reset_seen", int'(if0.seq_seen), 0);

        // Default config, overlapping 1011011.
        foreach (s1[i]) bit_in(s1[i]);
        idle();
        after_edge();
        chk("t1_count", int'(if0.match_count), 2);

        // Non-overlap 1011, load combined with a count clear.
        load(4'b1011, 0, 1);
        foreach (s1[i]) bit_in(s1[i]);
        idle();
        after_edge();
        chk("t2_count", int'(if0.match_count), 1);

        // Gapped stream: invalid cycles must be ignored.
        load(4'b1011, 1, 1);
        bit_in(1); repeat (3) idle();
        bit_in(0); repeat (3) idle();
        bit_in(1); repeat (3) idle();
        bit_in(1); repeat (3) idle();
        after_edge();
        chk("t3_count", int'(if0.match_count), 1);

        // All-ones pattern: consecutive pulses.
        load(4'b1111, 1, 1);
        repeat (7) bit_in(1);
        idle();
        after_edge();
        chk("t4_count", int'(if0.match_count), 4);
        chk("t4_sat_narrow", int'(if1.count_sat), 1);

        // Narrow counter saturates, then clears.
        drive(0, 0, 0, 0, 4'b0000, 0, 1);
        repeat (8) bit_in(1);
        idle();
        after_edge();
        chk("t5_count_narrow", int'(if1.match_count), 3);
        drive(0, 0, 0, 0, 4'b0000, 0, 1);
        after_edge();
        chk("t5_clear_narrow", int'(if1.match_count), 0);
        chk("t5_clear_sat", int'(if1.count_sat), 0);

        // Reset on the completing edge, after a non-default config.
        load(4'b0110, 0, 0);
        load(4'b1011, 0, 0);
        bit_in(1); bit_in(0); bit_in(1);
        drive(1, 1, 1, 0, 4'b0000, 0, 0);
        after_edge();
        chk("t6_reset_seen", int'(if0.seq_seen), 0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        bit_in(0); bit_in(1); bit_in(1);
        idle();
        after_edge();
        chk("t6_count", int'(if0.match_count), 2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 500) == 0, ($urandom % 10) < 7, 1'($urandom),
                  ($urandom % 60) == 0, 4'($urandom), 1'($urandom),
                  ($urandom % 150) == 0);
        end
        idle();
        after_edge();
        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
